// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the two handshakes of the fetch stage.
//   Memory side : mem_req/mem_addr out, mem_ack/mem_rdata back.
//   Decoder side: ins_valid/ins_data/ins_addr out, ins_ready back.
// The fetch stage uses the master modport. The memory and decoder
// (or a testbench standing in for them) use the slave modport.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  logic               ins_valid;
  logic               ins_ready;
  logic [INSTR_W-1:0] ins_data;
  logic [ADDR_W-1:0]  ins_addr;

  modport master (
    output mem_req, mem_addr, ins_valid, ins_data, ins_addr,
    input  mem_ack, mem_rdata, ins_ready
  );

  modport slave (
    input  mem_req, mem_addr, ins_valid, ins_data, ins_addr,
    output mem_ack, mem_rdata, ins_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage on the consumer side of the program counter. It reads one
// 16-bit instruction per request from instruction memory. It queues the
// instruction together with its address in a small prefetch FIFO for the
// decoder. It pulses pc_adv when a fetch completes. A flush throws away
// queued and in-flight work.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   pc_addr     address to fetch next (current PC)
//   flush       jump taken this cycle
//   pc_adv      comb pulse: PC may step by 2 on this edge
//   addr_fault  sticky: a misaligned pc_addr was seen
//   bus         memory request/ack and decoder valid/ready handshakes
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int ADDR_W  = 9,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  output logic              pc_adv,
  output logic              addr_fault,
  instr_fetch_if.master     bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0]  addr_mem [DEPTH];

  logic push;
  logic pop;

  // A fetch only lands when the live request (not a dropped one) is acked
  // without a jump in the same cycle.
  assign push = (state_q == REQ) && bus.mem_ack && !flush;
  assign pop  = (count_q != '0) && bus.ins_ready;

  assign pc_adv        = push;
  assign addr_fault    = fault_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ins_valid = (count_q != '0);
  assign bus.ins_data  = data_mem[rd_ptr_q];
  assign bus.ins_addr  = addr_mem[rd_ptr_q];

  // Request sequencing. A request is issued only with room in the FIFO, so a
  // completed fetch always has a slot. DROP exists because an issued request
  // cannot be withdrawn. It must still be acked, but its data is thrown away.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fault_d    = fault_q;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (pc_addr[0]) begin
            fault_d = 1'b1;
          end else if (!fault_q && (count_q < FULL)) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_addr;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping. A flush empties the queue and overrides any push or pop
  // on the same edge.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers. Reset drops mem_req at once, which aborts any
  // access that was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fault_q    <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage carries no reset. Entries are only read once count says they
  // were written.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.mem_rdata;
      addr_mem[wr_ptr_q] <= mem_addr_q;
    end
  end

  // Requests are only started with a free slot, so a push into a full FIFO
  // means the sequencing above is broken.
  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == FULL)));

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Randomised bench for instr_fetch. It plays the PC, the instruction memory
// and the decoder. It keeps a transaction-level model: one outstanding read
// that a jump can kill, an ordered queue of delivered instructions, and a
// sticky fault flag. Each cycle the model predicts the DUT outputs.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_addr;
  logic              flush;
  logic              pc_adv;
  logic              addr_fault;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_if ();

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .pc_adv     (pc_adv),
    .addr_fault (addr_fault),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  // Reference state: the PC, the outstanding read, and the queued instructions.
  entry_t            fifoModel[$];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] reqAddr;
  bit                reqLive;
  bit                reqKilled;
  bit                faultModel;
  int                reqWait;
  int                waitCnt;
  int                checks;
  int                fails;

  // Counts one comparison and reports it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Asserts reset in the middle of a cycle. The outputs are checked while reset
  // is held, and the model is cleared. Any outstanding read is abandoned.
  task automatic doReset();
    bus_if.mem_ack = 1'b1;
    flush = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("reset mem_req", bus_if.mem_req, 0);
    checkOutput("reset mem_addr", bus_if.mem_addr, 0);
    checkOutput("reset ins_valid", bus_if.ins_valid, 0);
    checkOutput("reset addr_fault", addr_fault, 0);
    checkOutput("reset pc_adv", pc_adv, 0);
    fifoModel.delete();
    reqLive    = 1'b0;
    reqKilled  = 1'b0;
    faultModel = 1'b0;
    waitCnt    = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Runs one clock cycle. The task drives random inputs and checks the outputs
  // at the falling edge. It then advances the model across the rising edge.
  task automatic applyStimulus(input int minWait, input int maxWait,
                               input int readyPct, input int flushPct,
                               input int noisePct);
    logic [7:0]        t8;
    logic [ADDR_W-1:0] target;
    bit                accept;
    int                sizeBefore;

    t8     = 8'($urandom_range(255));
    target = {t8, 1'b0};
    flush  = ($urandom_range(99) < flushPct);
    pc_addr = pc;
    bus_if.mem_rdata = INSTR_W'($urandom);
    bus_if.ins_ready = ($urandom_range(99) < readyPct);
    if (reqLive) bus_if.mem_ack = (waitCnt >= reqWait);
    else         bus_if.mem_ack = ($urandom_range(99) < noisePct);

    @(negedge clk);
    accept = reqLive && bus_if.mem_ack && !reqKilled && !flush;
    checkOutput("mem_req", bus_if.mem_req, reqLive);
    if (reqLive) checkOutput("mem_addr", bus_if.mem_addr, reqAddr);
    checkOutput("pc_adv", pc_adv, accept);
    checkOutput("ins_valid", bus_if.ins_valid, fifoModel.size() != 0);
    if (fifoModel.size() != 0) begin
      checkOutput("ins_addr", bus_if.ins_addr, fifoModel[0].addr);
      checkOutput("ins_data", bus_if.ins_data, fifoModel[0].data);
    end
    checkOutput("addr_fault", addr_fault, faultModel);

    // Decoder queue: a jump empties it. Otherwise the head leaves first and a
    // completed fetch joins at the tail.
    sizeBefore = fifoModel.size();
    if (flush) fifoModel.delete();
    else if (sizeBefore != 0 && bus_if.ins_ready) void'(fifoModel.pop_front());
    if (accept) fifoModel.push_back('{reqAddr, bus_if.mem_rdata});

    // Outstanding read: any ack retires it. A jump before the ack marks it
    // dead. With no read in flight, a new one starts if the PC is aligned,
    // no fault is set, and the queue has room.
    if (reqLive) begin
      if (bus_if.mem_ack) begin
        reqLive = 1'b0;
      end else begin
        waitCnt++;
        if (flush) reqKilled = 1'b1;
      end
    end else if (!flush) begin
      if (pc[0]) begin
        faultModel = 1'b1;
      end else if (!faultModel && sizeBefore < DEPTH) begin
        reqLive   = 1'b1;
        reqKilled = 1'b0;
        reqAddr   = pc;
        waitCnt   = 0;
        reqWait   = $urandom_range(maxWait, minWait);
      end
    end

    if (flush)       pc = target;
    else if (accept) pc = pc + ADDR_W'(2);

    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    pc     = '0;
    rst    = 1'b1;
    flush  = 1'b0;
    pc_addr = '0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = '0;
    bus_if.ins_ready = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    // Fast memory with a ready decoder: one fetch every two cycles.
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, 100, 0, 0);
    // Slow memory: three wait cycles per read.
    for (int i = 0; i < 30; i++) applyStimulus(3, 3, 100, 0, 50);
    // Decoder stalls until the queue fills, then drains it.
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 100, 0, 0);
    // Random jumps against varying memory latency and decoder back-pressure.
    for (int i = 0; i < 400; i++) applyStimulus(0, 3, 60, 10, 30);

    // Reset lands while a read is waiting for its ack.
    doReset();
    applyStimulus(5, 5, 100, 0, 0);
    doReset();

    // A misaligned PC raises the fault. The queue still drains, no new read
    // starts, and only reset clears the fault.
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
    pc = 9'h013;
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 100, 0, 40);
    doReset();
    pc = 9'h0A4;
    for (int i = 0; i < 1000; i++) applyStimulus(0, 4, 70, 8, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage that sits on the consumer side of the program counter. It takes the current instruction address, issues a read to instruction memory over a req/ack handshake, and buffers returned 16-bit instructions with their addresses in a small prefetch FIFO for the decoder. It tells the PC when to advance (`pc_adv`) and discards stale work on a jump (`flush`).

Parameters:
ADDR_W, 9, width of the byte address (matches the PC width)
INSTR_W, 16, instruction width; one instruction occupies 2 bytes
DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
pc_addr  in  ADDR_W  current PC value (address to fetch)
flush  in  1  jump taken this cycle; same signal as the PC's jmp
pc_adv  out  1  comb; one-cycle pulse, the PC may increment by 2 on this edge
mem_req  out  1  registered; memory read request
mem_addr  out  ADDR_W  registered; read address, stable while mem_req=1
mem_ack  in  1  memory accepts and returns data on this edge
mem_rdata  in  INSTR_W  read data, valid when mem_ack=1
ins_valid  out  1  FIFO non-empty
ins_ready  in  1  decoder accepts head entry
ins_data  out  INSTR_W  head instruction
ins_addr  out  ADDR_W  address of head instruction
addr_fault  out  1  sticky; a misaligned pc_addr was seen

Behaviour:
- Reset (async, rst=1): state=IDLE, FIFO count=0, rd/wr pointers=0, mem_req=0, mem_addr=0, addr_fault=0. Derived outputs: ins_valid=0, pc_adv=0. Reset during REQ drops mem_req immediately and aborts the access; memory must tolerate the abort.
- States:
  - IDLE: on an edge with !flush, !addr_fault, pc_addr[0]=0 and count<DEPTH, go to REQ. At that edge mem_addr<=pc_addr and mem_req<=1.
  - IDLE, pc_addr[0]=1 and !flush: set addr_fault<=1 and stay IDLE. The fault is sticky until rst and blocks all further requests. FIFO drain continues.
  - REQ: mem_req=1 and mem_addr is held. On mem_ack with !flush: push {mem_addr, mem_rdata}, assert pc_adv combinationally in that cycle, mem_req<=0, go to IDLE.
  - REQ, flush=1 with mem_ack in the same cycle: the data is discarded, pc_adv=0, go to IDLE.
  - REQ, flush=1 without mem_ack: go to DROP.
  - DROP: the request cannot be withdrawn, so mem_req stays 1 and mem_addr is unchanged. On mem_ack, discard the data, mem_req<=0, go to IDLE. Further flushes while in DROP stay in DROP.
- pc_adv = (state==REQ) & mem_ack & !flush. It is never asserted in IDLE or DROP.
- Timing:
  - Minimum 2 cycles per instruction: IDLE→REQ, then ack in the first REQ cycle.
  - Fetch-to-ins_valid latency is 1 edge after the ack edge.
  - mem_ack may be asserted in the first REQ cycle.
  - mem_ack is ignored in IDLE.
- FIFO:
  - ins_valid = (count!=0).
  - ins_data and ins_addr come from the head entry; their value is don't-care when empty.
  - Pop on ins_valid & ins_ready.
  - A push and a pop in the same edge leave count unchanged.
  - Push only happens from REQ, which is entered only with count<DEPTH, so overflow is impossible. A push at count==DEPTH is an assertion failure.
  - Pointers wrap modulo DEPTH.
- Flush priority: flush overrides pop and push; on that edge count<=0 and pointers<=0. ins_valid is 0 in the next cycle. The redirected pc_addr is sampled no earlier than the edge after the flush edge.
- Widths: internal arithmetic is in ADDR_W bits with no carry out. The address does not wrap here; wrap is the PC's concern.

Test Plan:
- Reset, pc_addr=0x000, mem_ack tied high, ins_ready=1 → mem_req at cycle 1 with mem_addr=0x000, pc_adv pulse in cycle 1. ins_valid with ins_addr=0x000 in cycle 2. Addresses 0x000, 0x002, 0x004 are fetched every 2 cycles.
- Memory acks after 3 wait cycles → mem_req/mem_addr stay stable for 4 cycles, exactly one pc_adv per fetch, ins_data equals mem_rdata.
- ins_ready=0 with fast memory → 4 entries are fetched, then mem_req stays 0. Raising ins_ready yields 4 in-order pops, then fetching resumes.
- flush during a REQ wait cycle (ack 2 cycles later) → state DROP, the acked data is not pushed, pc_adv stays 0, FIFO is empty. The next request uses the new pc_addr=0x0A4.
- flush in the same cycle as mem_ack, with 2 entries queued → nothing pushed, count=0 next cycle, pc_adv=0.
- pc_addr=0x013 in IDLE → addr_fault=1, no mem_req. The FIFO drains normally, and only rst clears the fault.
